// File: rtl/dense_in_framer.sv
// dense_in_framer: gathers a serial word stream into NB_INPUT-word frames and
// hands them to the dense stage through a ping-pong pair of frame banks.
`timescale 1ns/1ps
module dense_in_framer #(
   parameter int unsigned FIXED    = 32,
   parameter int unsigned NB_INPUT = 42,
   parameter int unsigned ERR_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [FIXED-1:0]          in_data,
   input  logic                      in_valid,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic [NB_INPUT*FIXED-1:0] frame,
   output logic                      frame_valid,
   input  logic                      frame_ready,
   output logic [ERR_W-1:0]          err_cnt,
   output logic [15:0]               frame_cnt
);

   localparam int unsigned IDX_W = $clog2(NB_INPUT);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_INPUT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [1:0]       full_q, full_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;

   logic [FIXED-1:0] bank_q [2][NB_INPUT];

   logic accept_c;
   logic transfer_c;

   // Handshake qualifiers; both depend only on registered state and rst_n.
   assign in_ready    = rst_n & ~full_q[wr_bank_q];
   assign frame_valid = rst_n & full_q[rd_bank_q];
   assign accept_c    = in_valid & in_ready;
   assign transfer_c  = frame_valid & frame_ready;
   assign err_cnt     = err_cnt_q;
   assign frame_cnt   = frame_cnt_q;

   // Next-state: word placement, frame completion/error and delivery bookkeeping.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      full_d      = full_q;
      idx_d       = idx_q;
      err_cnt_d   = err_cnt_q;
      frame_cnt_d = frame_cnt_q;

      // Completion and transfer never hit the same bank, so both may apply.
      if (transfer_c) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         frame_cnt_d       = 16'(frame_cnt_q + 16'd1);
      end

      if (accept_c) begin
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (in_last) begin
               full_d[wr_bank_q] = 1'b1;
               wr_bank_d         = ~wr_bank_q;
            end else if (err_cnt_q != ERR_MAX) begin
               err_cnt_d = err_cnt_q + ERR_W'(1);
            end
         end else if (in_last) begin
            idx_d = '0;
            if (err_cnt_q != ERR_MAX) begin
               err_cnt_d = err_cnt_q + ERR_W'(1);
            end
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= '0;
         idx_q       <= '0;
         err_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         idx_q       <= idx_d;
         err_cnt_q   <= err_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Frame storage; contents need no reset because full_q gates visibility.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         bank_q[wr_bank_q][idx_q] <= in_data;
      end
   end

   // Present the held bank flat, zeroed when nothing is held.
   always_comb begin
      frame = '0;
      if (frame_valid) begin
         for (int unsigned k = 0; k < NB_INPUT; k++) begin
            frame[k*FIXED +: FIXED] = bank_q[rd_bank_q][k];
         end
      end
   end

endmodule

// File: tb/tb_dense_in_framer.sv
// tb_dense_in_framer: directed checks of frame assembly, back-pressure,
// malformed-frame dropping, mid-frame reset and error-counter saturation.
`timescale 1ns/1ps
module tb_dense_in_framer;

   localparam int unsigned FIXED    = 32;
   localparam int unsigned NB_INPUT = 42;
   localparam int unsigned ERR_W    = 8;
   localparam int unsigned FRAME_W  = NB_INPUT * FIXED;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [FIXED-1:0]   in_data;
   logic               in_valid;
   logic               in_last;
   logic               in_ready;
   logic [FRAME_W-1:0] frame;
   logic               frame_valid;
   logic               frame_ready;
   logic [ERR_W-1:0]   err_cnt;
   logic [15:0]        frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [FIXED-1:0]   exp_w [NB_INPUT];
   logic [FRAME_W-1:0] got_q [$];

   dense_in_framer #(.FIXED(FIXED), .NB_INPUT(NB_INPUT), .ERR_W(ERR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .frame      (frame),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .err_cnt    (err_cnt),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   // Record every frame that will transfer on the coming rising edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1)
         got_q.push_back(frame);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_frame(input string tag, input logic [FRAME_W-1:0] f);
      for (int k = 0; k < NB_INPUT; k++)
         check($sformatf("%s[%0d]", tag, k), 64'(f[k*FIXED +: FIXED]), 64'(exp_w[k]));
   endtask

   task automatic set_exp(input logic [FIXED-1:0] base, input logic [FIXED-1:0] inc);
      for (int k = 0; k < NB_INPUT; k++)
         exp_w[k] = base + inc * FIXED'(k);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      in_valid    = 1'b0;
      in_last     = 1'b0;
      in_data     = '0;
      frame_ready = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_frame_valid", 64'(frame_valid), 64'd0);
      check("rst_frame_zero", 64'(|frame), 64'd0);
      repeat (cycles) tick();
      rst_n = 1'b1;
      got_q.delete();
      #1;
      check("post_rst_err", 64'(err_cnt), 64'd0);
      check("post_rst_fcnt", 64'(frame_cnt), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
   endtask

   // Present one word and hold it until accepted (bounded wait).
   task automatic send_word(input logic [FIXED-1:0] d, input logic last);
      int waited = 0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && waited < 200) begin
         tick();
         waited++;
      end
      if (waited >= 200) check("accept_timeout", 64'd0, 64'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [FIXED-1:0] base, input logic [FIXED-1:0] inc,
                             input int n, input logic last_at_end);
      for (int k = 0; k < n; k++)
         send_word(base + inc * FIXED'(k), last_at_end && (k == n - 1));
   endtask

   initial begin
      // 1: single frame 1..42, consumer ready
      do_reset(2);
      frame_ready = 1'b1;
      send_frame(32'd1, 32'd1, NB_INPUT, 1'b1);
      check("t1_valid_after_last", 64'(frame_valid), 64'd1);
      set_exp(32'd1, 32'd1);
      check_frame("t1_frame", frame);
      tick();
      check("t1_valid_one_cycle", 64'(frame_valid), 64'd0);
      check("t1_frame_zero", 64'(|frame), 64'd0);
      check("t1_fcnt", 64'(frame_cnt), 64'd1);
      check("t1_err", 64'(err_cnt), 64'd0);

      // 2: both banks fill under back-pressure, then drain in order
      do_reset(2);
      send_frame(32'h0000_0100, 32'd0, NB_INPUT, 1'b1);
      send_frame(32'hFFFF_FF00, 32'd0, NB_INPUT, 1'b1);
      check("t2_in_ready_stall", 64'(in_ready), 64'd0);
      check("t2_valid_A", 64'(frame_valid), 64'd1);
      set_exp(32'h0000_0100, 32'd0);
      check_frame("t2_hold_A", frame);
      repeat (3) tick();
      check("t2_valid_A_hold", 64'(frame_valid), 64'd1);
      check_frame("t2_stable_A", frame);
      check("t2_in_ready_still0", 64'(in_ready), 64'd0);
      frame_ready = 1'b1;
      tick();
      check("t2_valid_B", 64'(frame_valid), 64'd1);
      check("t2_in_ready_freed", 64'(in_ready), 64'd1);
      set_exp(32'hFFFF_FF00, 32'd0);
      check_frame("t2_frame_B", frame);
      tick();
      check("t2_drained", 64'(frame_valid), 64'd0);
      check("t2_fcnt", 64'(frame_cnt), 64'd2);

      // 3: short frame dropped, following frame delivered
      do_reset(2);
      frame_ready = 1'b1;
      send_frame(32'h0000_0A00, 32'd1, 10, 1'b1);
      check("t3_short_no_valid", 64'(frame_valid), 64'd0);
      check("t3_err_after_short", 64'(err_cnt), 64'd1);
      send_frame(32'h0000_1000, 32'd3, NB_INPUT, 1'b1);
      repeat (2) tick();
      check("t3_err", 64'(err_cnt), 64'd1);
      check("t3_fcnt", 64'(frame_cnt), 64'd1);
      check("t3_ndeliv", 64'(got_q.size()), 64'd1);
      set_exp(32'h0000_1000, 32'd3);
      if (got_q.size() > 0) check_frame("t3_frame", got_q[0]);

      // 4: long frame (no in_last) dropped, next frame intact
      do_reset(2);
      frame_ready = 1'b1;
      send_frame(32'h00A0_0000, 32'd1, NB_INPUT, 1'b0);
      check("t4_long_no_valid", 64'(frame_valid), 64'd0);
      check("t4_err_after_long", 64'(err_cnt), 64'd1);
      send_frame(32'h00B0_0000, 32'd7, NB_INPUT, 1'b1);
      repeat (2) tick();
      check("t4_err", 64'(err_cnt), 64'd1);
      check("t4_fcnt", 64'(frame_cnt), 64'd1);
      check("t4_ndeliv", 64'(got_q.size()), 64'd1);
      set_exp(32'h00B0_0000, 32'd7);
      if (got_q.size() > 0) check_frame("t4_frame", got_q[0]);

      // 5: reset after 20 words discards the partial frame silently
      do_reset(2);
      frame_ready = 1'b1;
      send_frame(32'h0C00_0000, 32'd1, 20, 1'b0);
      do_reset(1);
      frame_ready = 1'b1;
      send_frame(32'h0D00_0000, 32'd5, NB_INPUT, 1'b1);
      repeat (2) tick();
      check("t5_err", 64'(err_cnt), 64'd0);
      check("t5_fcnt", 64'(frame_cnt), 64'd1);
      check("t5_ndeliv", 64'(got_q.size()), 64'd1);
      set_exp(32'h0D00_0000, 32'd5);
      if (got_q.size() > 0) check_frame("t5_frame", got_q[0]);

      // 6: error counter saturation with single-word short frames
      do_reset(2);
      frame_ready = 1'b1;
      for (int i = 0; i < 254; i++) send_word(FIXED'(i), 1'b1);
      check("t6_err_254", 64'(err_cnt), 64'd254);
      send_word(32'd254, 1'b1);
      check("t6_err_255", 64'(err_cnt), 64'd255);
      for (int i = 255; i < 300; i++) send_word(FIXED'(i), 1'b1);
      check("t6_err_sat", 64'(err_cnt), 64'd255);
      check("t6_no_frames", 64'(frame_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dense_in_framer.md
Name: dense_in_framer

Overview:
- Collects a serial stream of fixed-point feature words into complete NB_INPUT-element frames.
- Presents each frame as one flat parallel vector to the dense layer input, using a valid/ready handshake.
- Ping-pong double buffer: one frame fills while the previous one is held for the dense stage.
- Malformed frames are detected, dropped and counted.

Parameters:
- FIXED, 32, word width in bits (same fixed-point format as the dense stage).
- NB_INPUT, 42, words per frame.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  FIXED  serial feature word.
- in_valid  input  1  in_data is valid.
- in_last  input  1  marks the final word of a frame; qualified by in_valid.
- in_ready  output  1  framer can accept a word.
- frame  output  NB_INPUT*FIXED  assembled frame; word k at bits [k*FIXED +: FIXED].
- frame_valid  output  1  frame holds a complete frame.
- frame_ready  input  1  dense stage consumes the frame.
- err_cnt  output  ERR_W  count of dropped frames, saturating.
- frame_cnt  output  16  frames delivered; wraps modulo 2^16.

Behaviour:
- Storage and state:
  - Two banks B0/B1, each NB_INPUT×FIXED registers.
  - State: wr_bank, rd_bank (1 bit each), full[1:0], idx (0..NB_INPUT-1).
- Reset (rst_n=0 at a clock edge):
  - wr_bank=rd_bank=0, full=0, idx=0, err_cnt=0, frame_cnt=0.
  - Outputs: frame_valid=0, frame=0, in_ready=0 while rst_n is low.
  - Bank contents are not reset.
  - Reset mid-frame discards the partial frame without incrementing err_cnt, and discards held frames.
- in_ready = rst_n & ~full[wr_bank]. This is registered-state driven, with no combinational path from in_valid.
- Accept = in_valid & in_ready. On accept, in_data is written to bank[wr_bank][idx]. Then:
  - idx<NB_INPUT-1, in_last=0: idx++.
  - idx==NB_INPUT-1, in_last=1: full[wr_bank]<=1, wr_bank toggles, idx<=0.
  - idx<NB_INPUT-1, in_last=1 (short frame): idx<=0, bank not marked full, err_cnt++.
  - idx==NB_INPUT-1, in_last=0 (long frame): the word is accepted and discarded, idx<=0, err_cnt++. The next word starts a new frame.
- err_cnt saturates at 2^ERR_W-1.
- Output side:
  - frame_valid = full[rd_bank].
  - frame = bank[rd_bank] when frame_valid, else all zeros.
  - Transfer = frame_valid & frame_ready. On transfer: full[rd_bank]<=0, rd_bank toggles, frame_cnt++.
  - frame and frame_valid are stable while frame_valid=1 and frame_ready=0.
- Latency:
  - The last word accepted at edge t gives frame_valid=1 after edge t (one cycle).
  - Back-to-back frames at one word per cycle sustain full throughput if frame_ready is high at least 1 cycle in every NB_INPUT.
- Both banks full: in_ready=0 and input stalls. in_ready rises the cycle after the transfer that frees a bank.
- Simultaneous completion and transfer on the same edge operate on different banks; both take effect. If wr_bank==rd_bank, that bank is empty, so no conflict is possible.
- frame_ready while frame_valid=0 is ignored.
- in_valid with in_ready=0 causes no state change. The source must hold in_data/in_last until accepted.

Test Plan:
- Reset, then feed words 1..42 (in_last on word 42), frame_ready=1 → frame_valid is high for 1 cycle, one cycle after the last accept. Word k = k+1 at [k*32 +: 32]; frame_cnt=1.
- frame_ready=0; send frames A (all 0x0000_0100) and B (all 0xFFFF_FF00) → in_ready=0 after B completes. Frame A is held stable. Raising frame_ready delivers A then B, then in_ready=1; frame_cnt=2.
- Send 10 words with in_last on word 10, then a valid 42-word frame → err_cnt=1; only the valid frame is delivered.
- Send 42 words without in_last, then 42 words with in_last on the last → first frame dropped (err_cnt=1); second frame delivered intact.
- Assert rst_n=0 for 1 cycle after 20 words of a frame, then send a full frame → err_cnt=0, frame_valid=0 during reset; only the new frame is delivered.
- Force 300 short frames → err_cnt saturates at 255.
